alu_seq_exec: RTL and testbench

- Sequential ALU execution unit. It consumes the 4-bit Operation code produced by the ALU controller, plus two operands, and returns a registered result.
- AND/OR/XOR/ADD/SUB/EQ/SLT complete in one cycle. Shifts run bit-serially, one bit position per cycle, to save area.
- Sits in the EX stage behind the ALU controller. Uses a valid/ready handshake on both input and output so the stall logic can hold the pipeline during multi-cycle shifts.

---
 rtl/alu_seq_exec.sv | 146 ++++++++++++++
 tb/tb_alu_seq_exec.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: sequential ALU execution unit for the EX stage.
//
// Logic, add/sub, compare and equality ops finish one cycle after accept. Shifts
// run bit-serially, one bit position per cycle, so an n-bit shift takes n+1
// cycles from accept to out_valid.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   Operation  4-bit opcode from the ALU controller
//   SrcA       operand A (shift source for shifts)
//   SrcB       operand B (low SHAMT_W bits are the shift amount for shifts)
//   in_valid   Operation/SrcA/SrcB are valid
//   in_ready   unit can accept an operation (high only when idle)
//   Result     registered result
//   Zero       registered Result == 0 flag
//   out_valid  Result/Zero are valid (high only when done)
//   out_ready  consumer accepts Result
module alu_seq_exec #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0011;
    localparam logic [3:0] OpSll = 4'b0100;
    localparam logic [3:0] OpSrl = 4'b0101;
    localparam logic [3:0] OpXor = 4'b0110;
    localparam logic [3:0] OpSra = 4'b0111;
    localparam logic [3:0] OpEq  = 4'b1000;
    localparam logic [3:0] OpSlt = 4'b1100;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e                 state_q;
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   zero_q;
    logic [DATA_WIDTH-1:0]  work_q;
    logic [SHAMT_W-1:0]     cnt_q;
    logic [3:0]             op_q;

    logic [DATA_WIDTH-1:0]  alu_res;
    logic [DATA_WIDTH-1:0]  shift_next;
    logic [SHAMT_W-1:0]     shamt;
    logic                   is_shift;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Result    = result_q;
    assign Zero      = zero_q;

    assign shamt    = SrcB[SHAMT_W-1:0];
    assign is_shift = (Operation == OpSll) || (Operation == OpSrl) || (Operation == OpSra);

    // Single-cycle result; undefined opcodes (and shifts, handled separately) give 0.
    always_comb begin
        alu_res = '0;
        case (Operation)
            OpAnd:   alu_res = SrcA & SrcB;
            OpOr:    alu_res = SrcA | SrcB;
            OpXor:   alu_res = SrcA ^ SrcB;
            OpAdd:   alu_res = SrcA + SrcB;
            OpSub:   alu_res = SrcA - SrcB;
            OpEq:    alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            OpSlt:   alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the working register for the captured shift opcode.
    always_comb begin
        shift_next = work_q;
        case (op_q)
            OpSll:   shift_next = {work_q[DATA_WIDTH-2:0], 1'b0};
            OpSrl:   shift_next = {1'b0, work_q[DATA_WIDTH-1:1]};
            default: shift_next = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (is_shift && (shamt != '0)) begin
                            work_q  <= SrcA;
                            cnt_q   <= shamt;
                            op_q    <= Operation;
                            state_q <= StShift;
                        end else if (is_shift) begin
                            result_q <= SrcA;
                            zero_q   <= (SrcA == '0);
                            state_q  <= StDone;
                        end else begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            state_q  <= StDone;
                        end
                    end
                end
                StShift: begin
                    work_q <= shift_next;
                    cnt_q  <= cnt_q - 1'b1;
                    // Last step: counter reaches zero on this edge.
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q <= shift_next;
                        zero_q   <= (shift_next == '0);
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int errors;

    alu_seq_exec #(
        .DATA_WIDTH(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Operation(Operation),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Result   (Result),
        .Zero     (Zero),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Independent reference: shifts use the language shift operators.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0110: return a ^ b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0100: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b0111: return $signed(a) >>> b[4:0];
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Issue one op, scramble inputs after accept, measure latency and check outputs.
    // If out_ready is high, also checks that in_ready returns the cycle after handshake.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez,
                          input int el);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({name, " ready_wait"}, 32'(in_ready), 32'd1);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        SrcA      = ~a;
        SrcB      = ~b;
        Operation = ~op;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(el));
        check({name, " Result"}, Result, er);
        check({name, " Zero"}, 32'(Zero), 32'(ez));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({name, " in_ready_after"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        Operation = 4'b0;
        SrcA      = '0;
        SrcB      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        vecs.push_back('{"SUB 5-5",   4'b0011, 32'd5,        32'd5,        32'd0,        1'b1, 1});
        vecs.push_back('{"ADD wrap",  4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1});
        vecs.push_back('{"XOR",       4'b0110, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0, 1});
        vecs.push_back('{"SLT -1<1",  4'b1100, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1});
        vecs.push_back('{"EQ 9,9",    4'b1000, 32'd9,        32'd9,        32'd1,        1'b0, 1});
        vecs.push_back('{"AND",       4'b0000, 32'h0000FF0F, 32'h00000FF0, 32'h00000F00, 1'b0, 1});
        vecs.push_back('{"SRA n=4",   4'b0111, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 5});
        vecs.push_back('{"SRL n=4",   4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 5});
        vecs.push_back('{"SLL 1<<31", 4'b0100, 32'd1,        32'd31,       32'h80000000, 1'b0, 32});
        vecs.push_back('{"SLL n=0",   4'b0100, 32'h00001234, 32'h00000020, 32'h00001234, 1'b0, 1});
        vecs.push_back('{"SLL to 0",  4'b0100, 32'h00000002, 32'd31,       32'd0,        1'b1, 32});
        vecs.push_back('{"UNDEF",     4'b1111, 32'h0000FFFF, 32'h0000FFFF, 32'd0,        1'b1, 1});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset Result", Result, 32'd0);
        check("reset Zero", 32'(Zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-shift: Result is 7 beforehand so the clear is visible
        run_op("ADD pre", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1);
        @(negedge clk);
        Operation = 4'b0100;
        SrcA      = 32'd1;
        SrcB      = 32'd20;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid-shift in_ready", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst Result", Result, 32'd0);
        check("rst Zero", 32'(Zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("ADD post", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res,
                   vecs[i].exp_zero, vecs[i].exp_lat);
        end

        // Backpressure
        out_ready = 1'b0;
        run_op("OR bp", 4'b0001, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid  = i[0];
            Operation = 4'b0010;
            SrcA      = 32'd100;
            SrcB      = 32'd1;
            #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp Result", Result, 32'hFF);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release Result", Result, 32'hFF);

        // Back-to-back random stream against the model
        begin
            logic [3:0] ops [11];
            ops = '{4'b0000, 4'b0001, 4'b0110, 4'b0010, 4'b0011, 4'b0100,
                    4'b0101, 4'b0111, 4'b1000, 4'b1100, 4'b1011};
            for (int i = 0; i < 8; i++) begin
                logic [3:0]  op;
                logic [31:0] a;
                logic [31:0] b;
                logic [31:0] er;
                op = ops[$urandom_range(0, 10)];
                a  = $urandom;
                b  = $urandom;
                if (i == 2) b = a;
                er = model(op, a, b);
                run_op($sformatf("rand%0d op%0h", i, op), op, a, b, er, (er == 32'd0),
                       model_lat(op, b));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
